// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter with built-in baud-tick divider.
// Frames are phase-aligned to request acceptance; tx and tx_done are registered.
module uart_tx_core #(
  parameter int BAUD_DIV   = 163,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] d_in,
  input  logic                 tx_start,
  output logic                 tx,
  output logic                 tx_done,
  output logic                 baud_tick
);

  localparam int DIV_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int TICK_MAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]  shreg_q, shreg_d;
  logic                  tx_q, tx_d;
  logic                  tx_done_q, tx_done_d;
  logic                  baud_tick_q, baud_tick_d;
  logic                  tick_s;
  logic                  accept_s;
  logic [DATA_BITS-1:0]  shreg_shift_s;

  assign tick_s        = (div_cnt_q == DIV_W'(BAUD_DIV - 1));
  assign accept_s      = (state_q == S_IDLE) && tx_start;
  assign shreg_shift_s = shreg_q >> 1;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    tx_d       = tx_q;
    tx_done_d  = 1'b0;
    if (tick_s) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_start) begin
          // Restarting the divider here makes every bit an exact multiple of BAUD_DIV clocks.
          shreg_d    = d_in;
          div_cnt_d  = '0;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          tx_d       = 1'b0;
          state_d    = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tick_s) begin
          if (tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            tx_d       = shreg_q[0];
            state_d    = S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      S_DATA: begin
        if (tick_s) begin
          if (tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) begin
            tick_cnt_d = '0;
            shreg_d    = shreg_shift_s;
            if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
              tx_d      = shreg_shift_s[0];
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (tick_s) begin
          if (tick_cnt_q == TICK_W'(STOP_TICKS - 1)) begin
            tick_cnt_d = '0;
            tx_done_d  = 1'b1;
            state_d    = S_IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    // Suppressed in the acceptance cycle so a BAUD_DIV of 1 shows the divider restart.
    baud_tick_d = (div_cnt_d == DIV_W'(BAUD_DIV - 1)) && !accept_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      tx_q        <= 1'b1;
      tx_done_q   <= 1'b0;
      baud_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      tx_q        <= tx_d;
      tx_done_q   <= tx_done_d;
      baud_tick_q <= baud_tick_d;
    end
  end

  assign tx        = tx_q;
  assign tx_done   = tx_done_q;
  assign baud_tick = baud_tick_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: BAUD_DIV=4 for frame behaviour, 1 and 7 for the divider.
module tb_uart_tx_core;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d_in4, d_in1, d_in7;
  logic       tx_start4, tx_start1, tx_start7;
  logic       tx4, tx1, tx7;
  logic       done4, done1, done7;
  logic       bt4, bt1, bt7;
  int         sel;
  logic       tx_m, done_m;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  uart_tx_core #(.BAUD_DIV(4)) u_dut4 (
    .clk(clk), .reset(reset), .d_in(d_in4), .tx_start(tx_start4),
    .tx(tx4), .tx_done(done4), .baud_tick(bt4));
  uart_tx_core #(.BAUD_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .d_in(d_in1), .tx_start(tx_start1),
    .tx(tx1), .tx_done(done1), .baud_tick(bt1));
  uart_tx_core #(.BAUD_DIV(7)) u_dut7 (
    .clk(clk), .reset(reset), .d_in(d_in7), .tx_start(tx_start7),
    .tx(tx7), .tx_done(done7), .baud_tick(bt7));

  always_comb begin
    tx_m   = tx4;
    done_m = done4;
    if (sel == 1) begin
      tx_m   = tx1;
      done_m = done1;
    end else if (sel == 7) begin
      tx_m   = tx7;
      done_m = done7;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the acceptance edge; returns #1 after the tx_done edge.
  task automatic check_frame(input logic [7:0] b, input int bw, input int pulse_at,
                             input int abort_at, input string tag);
    logic exp_tx;
    int   idx;
    for (int i = 0; i < 10 * bw; i++) begin
      if (i == abort_at) return;
      idx = i / bw;
      if (idx == 0)      exp_tx = 1'b0;
      else if (idx == 9) exp_tx = 1'b1;
      else               exp_tx = b[idx-1];
      chk({tag, "_tx"}, {31'd0, tx_m}, {31'd0, exp_tx});
      chk({tag, "_nodone"}, {31'd0, done_m}, 32'd0);
      if (pulse_at >= 0 && i == pulse_at)     tx_start4 = 1'b1;
      if (pulse_at >= 0 && i == pulse_at + 3) tx_start4 = 1'b0;
      step();
    end
    chk({tag, "_done"}, {31'd0, done_m}, 32'd1);
    chk({tag, "_done_tx"}, {31'd0, tx_m}, 32'd1);
  endtask

  task automatic check_idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_tx"}, {31'd0, tx_m}, 32'd1);
      chk({tag, "_done"}, {31'd0, done_m}, 32'd0);
      step();
    end
  endtask

  initial begin
    sel = 4;
    reset = 1'b1;
    d_in4 = 8'h99; d_in1 = 8'h00; d_in7 = 8'h00;
    tx_start4 = 1'b1; tx_start1 = 1'b0; tx_start7 = 1'b0;

    // Reset held with a pending request
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_tx", {31'd0, tx4}, 32'd1);
      chk("rst_done", {31'd0, done4}, 32'd0);
      chk("rst_tick", {31'd0, bt4}, 32'd0);
    end
    reset = 1'b0;
    tx_start4 = 1'b0;
    step();
    check_idle(100, "post_rst");

    // Divider period in IDLE, BAUD_DIV=4
    for (int k = 0; k < 8 && bt4 !== 1'b1; k++) step();
    chk("tick4_found", {31'd0, bt4}, 32'd1);
    for (int j = 1; j <= 12; j++) begin
      step();
      chk("tick4_period", {31'd0, bt4}, (j % 4 == 0) ? 32'd1 : 32'd0);
    end

    // Single byte with d_in changed right after acceptance
    d_in4 = 8'h99;
    tx_start4 = 1'b1;
    step();
    d_in4 = 8'h00;
    check_frame(8'h99, 64, -1, -1, "single");
    tx_start4 = 1'b0;
    step();
    check_idle(100, "single_after");

    // Back-to-back frames with tx_start held high
    d_in4 = 8'h99;
    tx_start4 = 1'b1;
    step();
    d_in4 = 8'hDA;
    check_frame(8'h99, 64, -1, -1, "b2b_first");
    step();
    check_frame(8'hDA, 64, -1, -1, "b2b_second");
    tx_start4 = 1'b0;
    step();
    check_idle(50, "b2b_after");

    // Request pulse and d_in change while busy
    d_in4 = 8'h99;
    tx_start4 = 1'b1;
    step();
    tx_start4 = 1'b0;
    d_in4 = 8'h00;
    check_frame(8'h99, 64, 300, -1, "busy");
    step();
    check_idle(700, "busy_after");

    // Reset during data bit 3, then a fresh frame
    d_in4 = 8'h55;
    tx_start4 = 1'b1;
    step();
    tx_start4 = 1'b0;
    check_frame(8'h55, 64, -1, 4 * 64 + 10, "pre_abort");
    chk("abort_bit3_low", {31'd0, tx4}, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_tx", {31'd0, tx4}, 32'd1);
    chk("abort_done", {31'd0, done4}, 32'd0);
    chk("abort_tick", {31'd0, bt4}, 32'd0);
    check_idle(700, "abort_idle");
    d_in4 = 8'h3C;
    tx_start4 = 1'b1;
    step();
    tx_start4 = 1'b0;
    check_frame(8'h3C, 64, -1, -1, "fresh");

    // BAUD_DIV=7: tick every 7 clocks, 112-clock bits
    sel = 7;
    for (int k = 0; k < 10 && bt7 !== 1'b1; k++) step();
    chk("tick7_found", {31'd0, bt7}, 32'd1);
    for (int j = 1; j <= 21; j++) begin
      step();
      chk("tick7_period", {31'd0, bt7}, (j % 7 == 0) ? 32'd1 : 32'd0);
    end
    d_in7 = 8'h0F;
    tx_start7 = 1'b1;
    step();
    check_frame(8'h0F, 112, -1, -1, "div7");
    tx_start7 = 1'b0;
    step();
    check_idle(20, "div7_after");

    // BAUD_DIV=1: tick always high except the acceptance cycle, 16-clock bits
    sel = 1;
    for (int j = 0; j < 16; j++) begin
      chk("tick1_idle", {31'd0, bt1}, 32'd1);
      step();
    end
    d_in1 = 8'hA3;
    tx_start1 = 1'b1;
    step();
    chk("tick1_accept", {31'd0, bt1}, 32'd0);
    check_frame(8'hA3, 16, -1, -1, "div1");
    tx_start1 = 1'b0;
    step();
    chk("tick1_after", {31'd0, bt1}, 32'd1);
    check_idle(20, "div1_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Transmit half of the UART: an internal baud-tick divider and an 8N1 serial transmitter in one block. It sits between the parallel producer (CPU or interface FSM) and the serial `tx` pin. It accepts a byte on a `tx_start` request and shifts it out LSB first, framed by one start bit and one stop bit. It signals completion with a one-cycle `tx_done` pulse.

## Interface
- `BAUD_DIV`, 163 — system clocks per baud tick; must be ≥1. 163 gives about 19200 baud ×16 at 50 MHz.
- `OVERSAMPLE`, 16 — baud ticks per serial bit.
- `DATA_BITS`, 8 — data bits per frame; `d_in` width.
- `STOP_TICKS`, 16 — baud ticks in the stop bit.
- One clock; reset is synchronous and active-high.
- `clk` input 1 — system clock; all logic on the rising edge.
- `reset` input 1 — synchronous, active-high reset.
- `d_in` input 8 — byte to send; sampled only when a request is accepted.
- `tx_start` input 1 — level request; accepted only in IDLE.
- `tx` output 1 — serial line; idles high.
- `tx_done` output 1 — one-cycle pulse at end of stop bit.
- `baud_tick` output 1 — one-cycle divider tick, for debug or a sibling receiver.

## Operation
- Baud divider: counter `div_cnt` counts 0..`BAUD_DIV`-1.
  - `baud_tick`=1 in the cycle where `div_cnt`==`BAUD_DIV`-1; the counter then wraps to 0.
  - Free-running in IDLE.
  - Forced to 0 on request acceptance, so every frame is phase-exact.
- Per-bit tick counter `tick_cnt`, 0..`OVERSAMPLE`-1. Bit index `bit_cnt`, 0..`DATA_BITS`-1. Shift register `shreg`, 8 bits.
- IDLE:
  - `tx`=1.
  - If `tx_start`=1 at a rising edge: latch `d_in` into `shreg`, clear `div_cnt` and `tick_cnt`, go to START.
- START:
  - `tx`=0.
  - On each `baud_tick`, increment `tick_cnt`.
  - On the `OVERSAMPLE`-th tick: clear `tick_cnt` and `bit_cnt`, go to DATA.
- DATA:
  - `tx`=`shreg[0]`.
  - After `OVERSAMPLE` ticks: shift `shreg` right by 1 and increment `bit_cnt`.
  - After bit `DATA_BITS`-1 completes, go to STOP. Data is sent LSB first.
- STOP:
  - `tx`=1.
  - After `STOP_TICKS` ticks: go to IDLE and assert `tx_done` for exactly one cycle.
- `tx` is registered, not decoded combinationally, so the line is glitch-free.
- `tx_start` outside IDLE is ignored. `d_in` changes during a frame are ignored.
- Back-to-back frames:
  - If `tx_start` is still 1 at the edge after `tx_done`, a new frame is accepted from IDLE with no extra idle bit time.
  - The producer drops `tx_start` on seeing `tx_done` to send a single byte.
- Reset, in any state including mid-frame, on the next rising edge:
  - State goes to IDLE; `tx`=1, `tx_done`=0.
  - `div_cnt`, `tick_cnt`, `bit_cnt` and `shreg` go to 0; `baud_tick`=0.

## Timing
- Let N=`BAUD_DIV` and B=`OVERSAMPLE`·N (clocks per bit).
- Request accepted at edge E0: `tx` falls to 0 at E0, a latency of one edge after `tx_start` is seen.
- Start bit occupies [E0, E0+B).
- Data bit k occupies [E0+(k+1)·B, E0+(k+2)·B).
- Stop bit occupies [E0+9B, E0+9B+`STOP_TICKS`·N).
- With the defaults, edge E0+10B sets state to IDLE and `tx_done`=1 for cycles [E0+10B, E0+10B+1).
- Earliest next acceptance is E0+10B+1.
- Total frame is 10B clocks with defaults.
- When N=1, `baud_tick` is constantly 1 except during the acceptance cycle, and B=16 clocks.

## Test plan
- Reset: hold `reset`=1 with `tx_start`=1 for 3 cycles → `tx`=1, `tx_done`=0, no frame starts. Release with `tx_start`=0 → `tx` stays 1 indefinitely.
- Single byte, `BAUD_DIV`=4: `d_in`=0x99, `tx_start`=1 until `tx_done` → `tx` = 0,1,0,0,1,1,0,0,1,1, each level held for 64 clocks.
  - `tx_done` pulses exactly once, 640 clocks after acceptance.
- Back-to-back: 0x99, then 0xDA with `tx_start` held high → the second frame begins at the edge after the first `tx_done`.
  - Second frame data bits = 0,1,0,1,1,0,1,1.
- Ignore while busy: mid-frame, change `d_in` to 0x00 and pulse `tx_start` → first frame still sends 0x99 and no extra frame follows.
- Reset mid-frame: assert `reset` during data bit 3 → `tx`=1 the next cycle with no `tx_done`. A fresh request afterwards produces a full, correctly timed frame.
- Divider: `BAUD_DIV`=1 and 7 → `baud_tick` period equals `BAUD_DIV` clocks in IDLE. Bit width is 16 and 112 clocks respectively.
